// File: rtl/uart_receiver.sv
// UART receiver: deserializes 8N1 frames from an asynchronous RX line into
// bytes. Each byte is handed to the consumer through a ready/valid handshake.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;

  localparam logic [CW-1:0] SYM_LAST    = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            rx_meta_r;
  logic            rx_s;

  // Two-flop synchronizer; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= serial_in;
      rx_s      <= rx_meta_r;
    end
  end

  // Frame FSM with registered byte, handshake and error-pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      count_r        <= CNT_ZERO;
      bit_idx_r      <= 3'd0;
      shift_r        <= 8'h00;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      // Error flags are pulses; they are only raised by the stop-bit sample.
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // Consumer takes the byte; a stop sample in this same cycle may reload it.
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            count_r <= CNT_ZERO;
            state_r <= START;
          end
        end

        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (count_r == SAMPLE_LAST) begin
            if (rx_s) begin
              state_r <= IDLE;
            end else begin
              count_r   <= CNT_ZERO;
              bit_idx_r <= 3'd0;
              state_r   <= DATA;
            end
          end else begin
            count_r <= count_r + CNT_ONE;
          end
        end

        DATA: begin
          // Counter was aligned to mid-bit in START, so a full symbol later
          // lands in the middle of each data bit. LSB arrives first.
          if (count_r == SYM_LAST) begin
            shift_r   <= {rx_s, shift_r[7:1]};
            count_r   <= CNT_ZERO;
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            count_r <= count_r + CNT_ONE;
          end
        end

        STOP: begin
          if (count_r == SYM_LAST) begin
            count_r <= CNT_ZERO;
            state_r <= IDLE;
            if (rx_s) begin
              // Slot is free if empty or being emptied this very cycle.
              if (!data_out_valid || data_out_ready) begin
                data_out       <= shift_r;
                data_out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            count_r <= count_r + CNT_ONE;
          end
        end

        default: begin
          state_r <= IDLE;
          count_r <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed test-plan frames plus
// random frames, compared against a transaction-level byte/flag model.
module tb_uart_receiver;

  localparam int BIT = 50_000_000 / 115_200;  // 434 cycles per bit

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  uart_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observation side
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         valid_cycles = 0;
  int         fe_cycles = 0;
  int         ov_cycles = 0;
  int         rise_cyc = 0;
  int         stable_viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;

  // Reference model: one-byte holding slot plus expected event counts
  logic [7:0] exp_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         exp_fe = 0;
  int         exp_ov = 0;
  int         seen = 0;
  int         start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_valid && data_out_ready) got_q.push_back(data_out);
      if (data_out_valid) valid_cycles++;
      if (framing_error) fe_cycles++;
      if (overrun) ov_cycles++;
      if (data_out_valid && !prev_valid) rise_cyc = cyc;
      if (!prev_rst && prev_valid && !prev_ready &&
          (!data_out_valid || data_out != prev_data)) stable_viol++;
    end
    prev_valid = data_out_valid;
    prev_ready = data_out_ready;
    prev_rst   = rst;
    prev_data  = data_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A frame as the model sees it: good stop bit fills the slot or overruns;
  // a ready consumer drains the slot immediately.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ready);
    if (!stop_ok) exp_fe++;
    else if (!m_valid) begin m_valid = 1'b1; m_byte = b; end
    else exp_ov++;
    if (ready && m_valid) begin exp_q.push_back(m_byte); m_valid = 1'b0; end
  endtask

  task automatic model_accept();
    if (m_valid) begin exp_q.push_back(m_byte); m_valid = 1'b0; end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int gap);
    start_cyc = cyc;
    serial_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (BIT) @(negedge clk);
    serial_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = seen; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    seen = exp_q.size();
  endtask

  task automatic check_slot(input string tag);
    check({tag, "_valid"}, data_out_valid, m_valid);
    if (m_valid) check({tag, "_data"}, data_out, m_byte);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_fe"}, fe_cycles, exp_fe);
    check({tag, "_ov"}, ov_cycles, exp_ov);
  endtask

  initial begin
    int v0;
    int lat;
    logic [7:0] rb;
    bit sb;

    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_ov", overrun, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, held without ready, then one-cycle accept
    send_frame(8'h78, 1'b1, 5);
    model_frame(8'h78, 1'b1, 1'b0);
    lat = rise_cyc - start_cyc;
    check("latency_window", (lat >= (19 * BIT) / 2 - 3) && (lat <= (19 * BIT) / 2 + 9), 1'b1);
    check_slot("hold_start");
    repeat (1000) @(negedge clk);
    check_slot("hold_1000");
    check("hold_stable", stable_viol, 0);
    data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
    model_accept();
    check("accept_valid_fall", data_out_valid, 1'b0);
    check_stream("accept");

    // Back-to-back frames, ready tied high
    data_out_ready = 1'b1;
    v0 = valid_cycles;
    send_frame(8'h79, 1'b1, 0);
    model_frame(8'h79, 1'b1, 1'b1);
    send_frame(8'h7a, 1'b1, 0);
    model_frame(8'h7a, 1'b1, 1'b1);
    send_frame(8'h0d, 1'b1, 20);
    model_frame(8'h0d, 1'b1, 1'b1);
    check("b2b_pulses", valid_cycles - v0, 3);
    check_stream("b2b");
    check_flags("b2b");

    // Short glitch on the line must not produce a byte
    v0 = valid_cycles;
    serial_in = 1'b0;
    repeat (100) @(negedge clk);
    serial_in = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_valid", valid_cycles - v0, 0);
    send_frame(8'h31, 1'b1, 20);
    model_frame(8'h31, 1'b1, 1'b1);
    check_stream("after_glitch");

    // Framing error, then a clean frame
    v0 = valid_cycles;
    send_frame(8'h35, 1'b0, 500);
    model_frame(8'h35, 1'b0, 1'b1);
    check("fe_no_valid", valid_cycles - v0, 0);
    check_flags("framing");
    send_frame(8'h3e, 1'b1, 20);
    model_frame(8'h3e, 1'b1, 1'b1);
    check_stream("after_fe");

    // Overrun: two frames with the consumer stalled
    data_out_ready = 1'b0;
    v0 = stable_viol;
    send_frame(8'h31, 1'b1, 0);
    model_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h3e, 1'b1, 20);
    model_frame(8'h3e, 1'b1, 1'b0);
    check_slot("overrun_hold");
    check_flags("overrun");
    check("overrun_stable", stable_viol - v0, 0);
    data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
    model_accept();
    repeat (300) @(negedge clk);
    check_slot("overrun_drained");
    check_stream("overrun");

    // Reset in the middle of data bit 4 while a byte is being held
    rb = 8'($urandom_range(0, 255));
    send_frame(rb, 1'b1, 10);
    model_frame(rb, 1'b1, 1'b0);
    check_slot("pre_reset_hold");
    rb = 8'hF0 | 8'($urandom_range(0, 15));
    fork
      send_frame(rb, 1'b1, 30);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data", data_out, 8'h00);
        check("midrst_valid", data_out_valid, 1'b0);
        check("midrst_fe", framing_error, 1'b0);
        check("midrst_ov", overrun, 1'b0);
        rst = 1'b0;
      end
    join
    m_valid = 1'b0;
    check_slot("post_abort");
    data_out_ready = 1'b1;
    send_frame(8'h20, 1'b1, 20);
    model_frame(8'h20, 1'b1, 1'b1);
    check_stream("after_reset");

    // Random frames with occasional bad stop bits and random idle gaps
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send_frame(rb, sb, sb ? int'($urandom_range(0, 50)) : BIT + int'($urandom_range(0, 100)));
      model_frame(rb, sb, 1'b1);
    end
    repeat (20) @(negedge clk);
    check_stream("random");
    check_flags("random");
    check_slot("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
